// File: rtl/acappella_pkg.sv
// Shared constants and types for the SDRAM arbiter: requester map, bus widths
// and the arbiter FSM state encoding.
package acappella_pkg;

   localparam int NUM_REQ = 5;
   localparam int ADDR_W  = 23;
   localparam int DATA_W  = 32;

   localparam int REQ_LOAD   = 0;
   localparam int REQ_MIX    = 1;
   localparam int REQ_PITCH  = 2;
   localparam int REQ_RECORD = 3;
   localparam int REQ_PLAY   = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RELEASE
   } arb_state_t;

   // Next slot in the 3-way round-robin ring (0 -> 1 -> 2 -> 0).
   function automatic logic [1:0] rr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin search over the three low-priority requesters,
// starting at the pointer slot.
module sdram_rr_picker
   import acappella_pkg::*;
(
   input  logic [1:0] ptr,
   input  logic [2:0] mask,
   output logic [1:0] winner,
   output logic       valid
);

   logic [1:0] c0, c1, c2;

   assign c0 = ptr;
   assign c1 = rr_inc(c0);
   assign c2 = rr_inc(c1);

   always_comb begin
      winner = 2'd0;
      valid  = 1'b1;
      if (mask[c0])      winner = c0;
      else if (mask[c1]) winner = c1;
      else if (mask[c2]) winner = c2;
      else               valid  = 1'b0;
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Single-owner SDRAM bus arbiter: fixed priority play > record, then
// round-robin over load/mix/pitch. One transaction at a time, no preemption.
module sdram_arbiter
   import acappella_pkg::*;
#(
   parameter int NUM_REQ = acappella_pkg::NUM_REQ,
   parameter int ADDR_W  = acappella_pkg::ADDR_W,
   parameter int DATA_W  = acappella_pkg::DATA_W
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [NUM_REQ-1:0]               req_read,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_writedata,
   output logic [DATA_W-1:0]                req_readdata,
   output logic [NUM_REQ-1:0]               req_finished,
   output logic [ADDR_W-1:0]                sdram_addr,
   output logic                             sdram_read,
   output logic                             sdram_write,
   output logic [DATA_W-1:0]                sdram_writedata,
   input  logic [DATA_W-1:0]                sdram_readdata,
   input  logic                             sdram_finished,
   output logic [2:0]                       grant_id,
   output logic                             busy,
   output logic                             arb_error
);

   arb_state_t           state;
   logic [1:0]           rr_ptr;
   logic [NUM_REQ-1:0]   pending;
   logic [1:0]           rr_win;
   logic                 rr_valid;
   logic [2:0]           win_id;
   logic                 win_valid;
   logic                 win_rr;
   logic                 win_wr;
   logic                 win_both;

   assign pending = req_read | req_write;

   sdram_rr_picker u_rr (
      .ptr    (rr_ptr),
      .mask   (pending[2:0]),
      .winner (rr_win),
      .valid  (rr_valid)
   );

   always_comb begin
      win_id = {1'b0, rr_win};
      win_rr = 1'b0;
      if (pending[REQ_PLAY])        win_id = 3'(REQ_PLAY);
      else if (pending[REQ_RECORD]) win_id = 3'(REQ_RECORD);
      else                          win_rr = rr_valid;
      win_valid = |pending;
      win_wr    = req_write[win_id];
      win_both  = req_read[win_id] & req_write[win_id];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= IDLE;
         rr_ptr          <= 2'd0;
         sdram_addr      <= '0;
         sdram_writedata <= '0;
         sdram_read      <= 1'b0;
         sdram_write     <= 1'b0;
         req_finished    <= '0;
         req_readdata    <= '0;
         grant_id        <= 3'd0;
         busy            <= 1'b0;
         arb_error       <= 1'b0;
      end else begin
         req_finished <= '0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  grant_id        <= win_id;
                  sdram_addr      <= req_addr[win_id];
                  sdram_writedata <= req_writedata[win_id];
                  // Read+write together resolves to a write and is flagged.
                  sdram_write     <= win_wr;
                  sdram_read      <= ~win_wr;
                  busy            <= 1'b1;
                  if (win_both) arb_error <= 1'b1;
                  if (win_rr)   rr_ptr    <= rr_inc(rr_win);
                  state           <= BUSY;
               end
            end
            BUSY: begin
               if (sdram_finished) begin
                  sdram_read             <= 1'b0;
                  sdram_write            <= 1'b0;
                  req_finished[grant_id] <= 1'b1;
                  if (sdram_read) req_readdata <= sdram_readdata;
                  state                  <= RELEASE;
               end
            end
            RELEASE: begin
               // Requests are ignored here so the just-served requester has
               // time to drop its level request.
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, number of requesters (0 load, 1 mix, 2 pitch, 3 record, 4 play).
REQ-002 SHALL have parameter ADDR_W, default 23, SDRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 32, SDRAM data width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 i_clk  in  1  clock, all logic on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 req_read  in  NUM_REQ  per-requester read request, level, held until finished.
REQ-008 req_write  in  NUM_REQ  per-requester write request, level, held until finished.
REQ-009 req_addr  in  NUM_REQ x ADDR_W  per-requester address, stable while request high.
REQ-010 req_writedata  in  NUM_REQ x DATA_W  per-requester write data, stable while request high.
REQ-011 req_readdata  out  DATA_W  last completed read data, broadcast to all requesters.
REQ-012 req_finished  out  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-013 sdram_addr, sdram_read, sdram_write, sdram_writedata  out  ADDR_W/1/1/DATA_W  to SDRAM bus.
REQ-014 sdram_readdata, sdram_finished  in  DATA_W/1  from SDRAM bus; finished is a one-cycle pulse.
REQ-015 grant_id  out  3  index of the current owner (debug); busy  out  1  transaction in flight.
REQ-016 arb_error  out  1  sticky flag: a requester asserted read and write together.

Function
REQ-017 FSM states: IDLE, BUSY, RELEASE.
REQ-018 IDLE: if any request is pending, latch winner index, address, data and op; go to BUSY next cycle.
REQ-019 Priority: play (4) over record (3) over round-robin among 0..2.
REQ-020 RR pointer starts at 0; after a grant to i in {0,1,2}, pointer becomes (i+1) mod 3; search begins at pointer.
REQ-021 Grants to 3 or 4 leave the RR pointer unchanged.
REQ-022 BUSY: sdram_read or sdram_write held high from latched op; sdram_addr and sdram_writedata come from latches.
REQ-023 BUSY: strobes stay high until the cycle in which sdram_finished=1.
REQ-024 sdram_finished in BUSY at cycle M: strobes low from M+1.
REQ-025 Same completion: req_finished[grant] pulses in M+1; for reads, req_readdata is updated in M+1 and holds until the next read completes.
REQ-026 Same completion: FSM is in RELEASE at M+1 and IDLE at M+2.
REQ-027 Requester SHALL drop its request by M+2; RELEASE ignores all requests, so there is no double issue.
REQ-028 Minimum latency is 1 cycle from a request seen in IDLE to strobe high; back-to-back grants are 3 cycles apart plus SDRAM time.
REQ-029 No preemption: a higher-priority request arriving in BUSY waits for RELEASE→IDLE.
REQ-030 Read and write both high on the winner: treat as write, set arb_error (cleared only by reset).
REQ-031 sdram_finished outside BUSY SHALL be ignored: no req_finished pulse, no state change.
REQ-032 A request dropped while not granted is simply not served.
REQ-033 Outputs are never driven from more than one requester; address bus OR-ing is prohibited.
REQ-034 busy=1 in BUSY and RELEASE.
REQ-035 grant_id holds the latched winner from BUSY until the next grant; 0 after reset.

Reset
REQ-036 On i_rst: state IDLE, strobes 0, sdram_addr/writedata 0, req_finished 0, req_readdata 0, grant_id 0, busy 0, arb_error 0, RR pointer 0.
REQ-037 Reset mid-BUSY: strobes low the following cycle, no req_finished pulse, transaction abandoned.

Structure
REQ-038 Package acappella_pkg SHALL hold NUM_REQ, ADDR_W, DATA_W, requester index constants (REQ_LOAD..REQ_PLAY) and the FSM state enum.
REQ-039 Sub-module sdram_rr_picker SHALL implement the 3-way round-robin search (pointer in, request mask in, winner and valid out, combinational).
REQ-040 Arbiter FSM, latches and priority mux SHALL stay in sdram_arbiter.

Verification
REQ-041 Single write, mix addr 0x000100, data 0xDEADBEEF, SDRAM finished 4 cycles later -> sdram_write high for exactly the BUSY cycles, addr/data match, req_finished=5'b00010 one cycle.
REQ-042 Single read, play addr 0x7FFFFF, readdata 0x12345678 -> req_readdata=0x12345678 in the same cycle as req_finished[4], held afterwards.
REQ-043 Requests 0, 1, 2 held continuously -> grant order 0, 1, 2, 0, 1, 2.
REQ-044 Record and play arrive in the same cycle with load pending -> order play, record, load.
REQ-045 Reset asserted while BUSY -> strobes 0 next cycle, no finished pulse, grant_id=0; a stray sdram_finished afterwards is ignored.
REQ-046 Pitch asserts read and write together -> write issued, arb_error=1 and remains 1 until reset.
